dt_integrator: RTL

Reconstructs a temperature trajectory from the dT stream produced by the derivative path. Each valid dT sample (Q7.0), scaled by 2^k, is accumulated into a saturating temperature register bounded by programmable limits. The block sits downstream of the dT estimator in DT_MODE loopback and model-check builds. It re-seeds cleanly on an INIT pulse, without an output spike.

---
 rtl/dt_integrator_if.sv | 27 ++
 rtl/dt_integrator.sv | 109 ++++++++++
 2 files changed

// File: rtl/dt_integrator_if.sv
// Sample/limit/config bus of dt_integrator. The master drives the dT stream and
// limits; the slave (the integrator) returns the reconstructed temperature and status.
interface dt_integrator_if;
    logic       init;
    logic [7:0] T_seed;
    logic [7:0] dT_in;
    logic       dt_valid;
    logic [2:0] k_dt;
    logic [7:0] t_min;
    logic [7:0] t_max;
    logic [7:0] T_out;
    logic       t_valid;
    logic       sat_hi;
    logic       sat_lo;
    logic       cfg_err;
    logic [7:0] sat_cnt;

    modport master (
        output init, T_seed, dT_in, dt_valid, k_dt, t_min, t_max,
        input  T_out, t_valid, sat_hi, sat_lo, cfg_err, sat_cnt
    );

    modport slave (
        input  init, T_seed, dT_in, dt_valid, k_dt, t_min, t_max,
        output T_out, t_valid, sat_hi, sat_lo, cfg_err, sat_cnt
    );
endinterface

// File: rtl/dt_integrator.sv
// Saturating integrator rebuilding temperature from scaled dT samples.
// Optional: DT_INTEGRATOR_SATCNT_EN builds the clamp counter (sat_cnt); otherwise sat_cnt = 0.
module dt_integrator #(
    parameter int ACC_W = 16
) (
    input logic            clk,
    input logic            rst,
    dt_integrator_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    tv_q, tv_d;
    logic                    hi_q, hi_d;
    logic                    lo_q, lo_d;

    logic signed [ACC_W-1:0] step_w;
    logic signed [ACC_W:0]   lim_lo_w, lim_hi_w, seed_w, sum_w;
    logic                    limits_bad, accept, over, under;

    // Everything is compared at ACC_W+1 bits so the sum can never wrap.
    assign lim_lo_w   = (ACC_W+1)'($signed(bus.t_min));
    assign lim_hi_w   = (ACC_W+1)'($signed(bus.t_max));
    assign seed_w     = (ACC_W+1)'($signed(bus.T_seed));
    assign step_w     = ACC_W'($signed(bus.dT_in)) <<< bus.k_dt;
    assign sum_w      = (ACC_W+1)'(acc_q) + (ACC_W+1)'(step_w);
    assign limits_bad = $signed(bus.t_min) > $signed(bus.t_max);
    assign accept     = (state_q == S_RUN) && bus.dt_valid && !bus.init && !limits_bad;
    assign over       = sum_w > lim_hi_w;
    assign under      = sum_w < lim_lo_w;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tv_d    = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (bus.init) begin
            // Seed is clamped too, so T_out never jumps outside the window.
            if (seed_w > lim_hi_w)      acc_d = lim_hi_w[ACC_W-1:0];
            else if (seed_w < lim_lo_w) acc_d = lim_lo_w[ACC_W-1:0];
            else                        acc_d = seed_w[ACC_W-1:0];
            hi_d    = 1'b0;
            lo_d    = 1'b0;
            state_d = (state_q == S_IDLE || !limits_bad) ? S_RUN : S_FAULT;
        end else if (state_q == S_RUN) begin
            if (limits_bad) begin
                state_d = S_FAULT;
            end else if (bus.dt_valid) begin
                tv_d = 1'b1;
                hi_d = over;
                lo_d = under;
                if (over)       acc_d = lim_hi_w[ACC_W-1:0];
                else if (under) acc_d = lim_lo_w[ACC_W-1:0];
                else            acc_d = sum_w[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            tv_q    <= 1'b0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tv_q    <= tv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

`ifdef DT_INTEGRATOR_SATCNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.init)
            cnt_d = '0;
        else if (accept && (over || under) && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.sat_cnt = cnt_q;
`else
    assign bus.sat_cnt = '0;
`endif

    assign bus.T_out   = acc_q[7:0];
    assign bus.t_valid = tv_q;
    assign bus.sat_hi  = hi_q;
    assign bus.sat_lo  = lo_q;
    assign bus.cfg_err = (state_q == S_FAULT);

    // accept is only consumed by the optional counter
    logic unused_ok;
    assign unused_ok = accept;
endmodule
